bus_burst_memory_slave: RTL and testbench
=========================================

Name: bus_burst_memory_slave

Overview:
- Burst-capable bus slave memory. Sits directly downstream of the ramDmaCi bus master port and answers its single and burst read/write transactions.
- Replaces the hand-driven bus stimulus in DMA benches and serves as on-chip scratch memory in the system.
- Internal word array of 2^addressBits x 32 bits, with configurable read latency and periodic stall insertion.

Parameters:
- baseAddress, 32'h00000000, byte address of word 0; must be 4-byte aligned.
- addressBits, 10, log2 of the number of 32-bit words (default 1024 words = 4 KiB).
- readLatency, 2, idle cycles between accepting a read and returning the first word; range 1..15.
- stallPeriod, 0, a one-cycle stall is inserted after every stallPeriod words; 0 disables stalls.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- busIn_begin_transaction  in  1  one-cycle pulse from the master; starts a transaction.
- busIn_address_data  in  32  byte address while begin is high; write data while busIn_data_valid is high.
- busIn_read_n_write  in  1  sampled with begin: 1 = read, 0 = write.
- busIn_burst_size  in  8  sampled with begin: word count minus 1 (0 = single word).
- busIn_byte_enables  in  4  write byte lanes; bit i enables bits 8i+7:8i.
- busIn_data_valid  in  1  write data is valid this cycle.
- busIn_end_transaction  in  1  master has terminated a write burst.
- busOut_address_data  out  32  read data; all zeros whenever busOut_data_valid is low (the bus is wired-OR).
- busOut_data_valid  out  1  read word valid this cycle.
- busOut_end_transaction  out  1  one-cycle pulse ending a read or error response.
- busOut_busy  out  1  slave is stalling write acceptance this cycle.
- busOut_error  out  1  one-cycle pulse: transaction rejected.

Behaviour:
- Reset: every output is 0 and the state is IDLE, asynchronously; a reset mid-burst aborts the burst. Memory contents are not cleared and are undefined after power-up.
- States: IDLE, CHECK, READ_WAIT, READ_BURST, READ_END, WRITE, ERROR.
- IDLE:
  - busIn_begin_transaction=1 latches address, read_n_write, burst_size and count=burst_size+1, then moves to CHECK.
  - A begin pulse in any state other than IDLE is ignored.
- CHECK (one cycle). Error if any of these holds:
  - address[1:0] != 0;
  - address < baseAddress;
  - word index (address-baseAddress)>>2 plus burst_size >= 2^addressBits. No wrap-around: a burst that crosses the end of memory is rejected as a whole.
  - Error goes to ERROR. Otherwise a read goes to READ_WAIT and a write goes to WRITE. Pointer = word index.
- ERROR:
  - busOut_error=1 and busOut_end_transaction=1 together for exactly one cycle, then IDLE.
  - Write data offered during an errored transaction is never written.
  - For a write, the slave still waits in IDLE-compatible fashion: later busIn_data_valid and busIn_end_transaction pulses are ignored.
- READ_WAIT: outputs stay low for readLatency cycles, then READ_BURST.
- READ_BURST:
  - Drives mem[pointer] with busOut_data_valid=1 on consecutive cycles; pointer increments and count decrements per word.
  - If stallPeriod>0, after every stallPeriod words that are not the last word, insert one cycle with data_valid=0 and data=0.
  - When count reaches 0, go to READ_END.
- READ_END: busOut_end_transaction=1 for one cycle, then IDLE. A new begin is accepted in the cycle after this pulse.
- WRITE:
  - Each cycle with busIn_data_valid=1 and busOut_busy=0 writes the enabled byte lanes of busIn_address_data to mem[pointer], then pointer++ and count--.
  - A data_valid cycle while busy=1 is not accepted; the master holds the word.
  - If stallPeriod>0, busOut_busy=1 for the one cycle following every stallPeriod-th accepted word.
  - Words offered after count reaches 0 are discarded.
  - busIn_end_transaction=1 returns the slave to IDLE. If data_valid is high in the same cycle, that word is written first (if count>0).
  - The slave never pulses end_transaction for writes.
- Read data path: synchronous memory read one cycle ahead, so words are back-to-back with no bubble at stallPeriod=0.
- Latency, read: begin at edge T, first data at edge T+2+readLatency, end pulse one cycle after the last word.

Test Plan:
- Write 4 words 0x11,0x22,0x33,0x44 at baseAddress+0x10 (burst_size=3, byte_enables=4'hF, stallPeriod=0), end; then read the same burst -> data_valid for 4 consecutive cycles starting 4 cycles after begin, data 0x11..0x44 in order, then one end pulse.
- Write word 0xAABBCCDD at 0x20, then write 0x00000099 with byte_enables=4'b0001, then a single read -> 0xAABBCC99.
- With stallPeriod=2, read 5 words -> valid pattern 1,1,0,1,1,0,1 then end. Write 6 words -> busy high after the 2nd and 4th accepted word; a word held across busy is written exactly once.
- Misaligned address 0x22, address below base, and a burst at word 1020 with burst_size=7 (addressBits=10) -> each gives error plus end for one cycle, no data_valid, memory unchanged.
- Reset asserted during word 3 of an 8-word read -> outputs 0 immediately, state IDLE; the next read returns previously written data.
- Begin pulse during READ_BURST -> ignored, current burst completes unchanged. Begin one cycle after the end pulse -> accepted.

Source files
------------

// File: rtl/bus_burst_memory_slave.sv
// rtl/bus_burst_memory_slave.sv - burst-capable bus slave scratch memory
//
// Word-addressed memory of 2^addressBits x 32 bits that answers single and
// burst read/write transactions from a bus master. Reads return data after a
// configurable latency; an optional one-cycle stall is inserted after every
// stallPeriod words in both directions.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   busIn_begin_transaction      one-cycle start pulse (address/direction/size sampled)
//   busIn_address_data           byte address with begin, write data with data_valid
//   busIn_read_n_write           1 = read, 0 = write
//   busIn_burst_size             word count minus one
//   busIn_byte_enables           write byte lanes
//   busIn_data_valid             write word offered this cycle
//   busIn_end_transaction        master terminates a write burst
//   busOut_address_data          read data, forced to zero when not valid
//   busOut_data_valid            read word valid
//   busOut_end_transaction       end pulse of a read or error response
//   busOut_busy                  write word not accepted this cycle
//   busOut_error                 transaction rejected pulse
module bus_burst_memory_slave #(
    parameter logic [31:0] baseAddress = 32'h0000_0000,
    parameter int          addressBits = 10,
    parameter int          readLatency = 2,
    parameter int          stallPeriod = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        busIn_begin_transaction,
    input  logic [31:0] busIn_address_data,
    input  logic        busIn_read_n_write,
    input  logic [7:0]  busIn_burst_size,
    input  logic [3:0]  busIn_byte_enables,
    input  logic        busIn_data_valid,
    input  logic        busIn_end_transaction,
    output logic [31:0] busOut_address_data,
    output logic        busOut_data_valid,
    output logic        busOut_end_transaction,
    output logic        busOut_busy,
    output logic        busOut_error
);

    localparam int unsigned DEPTH     = 1 << addressBits;
    localparam logic [32:0] LIMIT     = 33'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(readLatency - 1);
    localparam logic [8:0]  STALL_N   = 9'(stallPeriod);
    localparam bit          STALL_EN  = (stallPeriod > 0);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ_WAIT,
        READ_BURST,
        READ_END,
        WRITE,
        ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic                   rnw_q, rnw_d;
    logic [7:0]             burst_q, burst_d;
    logic [8:0]             count_q, count_d;
    logic [addressBits-1:0] ptr_q, ptr_d;
    logic [3:0]             wait_q, wait_d;
    logic [7:0]             run_q, run_d;      // words moved since the last stall
    logic                   stall_q, stall_d;  // read bubble owed this cycle
    logic                   valid_q, valid_d;
    logic                   end_q, end_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;

    logic [31:0]            mem [DEPTH];
    logic [31:0]            rdata_q;
    logic                   mem_we;
    logic                   accept;
    logic                   run_full;
    logic [29:0]            word_idx;
    logic [32:0]            last_idx;
    logic                   range_err;

    // Range check on the latched transaction; the whole burst must fit, no wrap.
    assign word_idx  = 30'((addr_q - baseAddress) >> 2);
    assign last_idx  = {3'b000, word_idx} + {25'd0, burst_q};
    assign range_err = (addr_q[1:0] != 2'b00) || (addr_q < baseAddress) || (last_idx >= LIMIT);

    assign run_full  = STALL_EN && (({1'b0, run_q} + 9'd1) == STALL_N);
    assign accept    = busIn_data_valid && !busy_q && (count_q != 9'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        burst_d = burst_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        run_d   = run_q;
        stall_d = stall_q;
        valid_d = 1'b0;
        end_d   = 1'b0;
        busy_d  = 1'b0;
        error_d = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (busIn_begin_transaction) begin
                    addr_d  = busIn_address_data;
                    rnw_d   = busIn_read_n_write;
                    burst_d = busIn_burst_size;
                    count_d = {1'b0, busIn_burst_size} + 9'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                ptr_d   = word_idx[addressBits-1:0];
                run_d   = 8'd0;
                stall_d = 1'b0;
                wait_d  = WAIT_INIT;
                if (range_err) begin
                    state_d = ERROR;
                end else if (rnw_q) begin
                    state_d = READ_WAIT;
                end else begin
                    state_d = WRITE;
                end
            end
            ERROR: begin
                error_d = 1'b1;
                end_d   = 1'b1;
                state_d = IDLE;
            end
            READ_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = READ_BURST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            READ_BURST: begin
                if (stall_q) begin
                    stall_d = 1'b0;
                end else begin
                    // rdata_q captures mem[ptr_q] on the same edge valid rises
                    valid_d = 1'b1;
                    ptr_d   = ptr_q + addressBits'(1);
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = READ_END;
                    end else if (run_full) begin
                        run_d   = 8'd0;
                        stall_d = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
            end
            READ_END: begin
                end_d   = 1'b1;
                state_d = IDLE;
            end
            WRITE: begin
                if (accept) begin
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + addressBits'(1);
                    count_d = count_q - 9'd1;
                    if (run_full) begin
                        run_d  = 8'd0;
                        busy_d = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end
                if (busIn_end_transaction) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            rnw_q   <= 1'b0;
            burst_q <= 8'd0;
            count_q <= 9'd0;
            ptr_q   <= '0;
            wait_q  <= 4'd0;
            run_q   <= 8'd0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            burst_q <= burst_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            run_q   <= run_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    // Storage is deliberately not reset so contents survive a bus reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (busIn_byte_enables[i]) begin
                    mem[ptr_q][8*i +: 8] <= busIn_address_data[8*i +: 8];
                end
            end
        end
        rdata_q <= mem[ptr_q];
    end

    // Wired-OR bus: the data lines must be zero whenever no word is driven.
    assign busOut_address_data    = valid_q ? rdata_q : 32'h0;
    assign busOut_data_valid      = valid_q;
    assign busOut_end_transaction = end_q;
    assign busOut_busy            = busy_q;
    assign busOut_error           = error_q;

endmodule

// File: tb/tb_bus_burst_memory_slave.sv
// tb/tb_bus_burst_memory_slave.sv - self-checking bench for bus_burst_memory_slave
module tb_bus_burst_memory_slave;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 3;
    localparam int          PER0  = 0;
    localparam int          PER1  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        begin_t;
    logic [31:0] ad;
    logic        rnw;
    logic [7:0]  bsz;
    logic [3:0]  be;
    logic        dv;
    logic        endt;
    int          sel;

    logic        beg0, beg1;
    logic [31:0] o_ad0, o_ad1;
    logic        o_dv0, o_dv1, o_end0, o_end1, o_busy0, o_busy1, o_err0, o_err1;
    logic [31:0] r_ad;
    logic        r_dv, r_end, r_busy, r_err;

    int checks   = 0;
    int failures = 0;
    int flag_err, flag_end, flag_dv, flag_mis;

    logic [31:0] mm [2][DEPTH];

    typedef struct {
        logic        v;
        logic [31:0] data;
        logic        e;
    } beat_t;

    typedef struct {
        int          d;
        bit          rd;
        logic [31:0] addr;
        logic [7:0]  burst;
        int          n;
        logic [3:0]  bm;
        logic [31:0] d0;
        logic [31:0] step;
        bit          err;
        bit          inject;
    } vec_t;

    always #5 clock = ~clock;

    assign beg0 = begin_t && (sel == 0);
    assign beg1 = begin_t && (sel == 1);

    bus_burst_memory_slave #(.baseAddress(BASE0), .addressBits(AW), .readLatency(LAT0), .stallPeriod(PER0)) dut0 (
        .clock(clock), .reset(reset),
        .busIn_begin_transaction(beg0), .busIn_address_data(ad), .busIn_read_n_write(rnw),
        .busIn_burst_size(bsz), .busIn_byte_enables(be), .busIn_data_valid(dv && sel == 0),
        .busIn_end_transaction(endt && sel == 0),
        .busOut_address_data(o_ad0), .busOut_data_valid(o_dv0), .busOut_end_transaction(o_end0),
        .busOut_busy(o_busy0), .busOut_error(o_err0)
    );

    bus_burst_memory_slave #(.baseAddress(BASE1), .addressBits(AW), .readLatency(LAT1), .stallPeriod(PER1)) dut1 (
        .clock(clock), .reset(reset),
        .busIn_begin_transaction(beg1), .busIn_address_data(ad), .busIn_read_n_write(rnw),
        .busIn_burst_size(bsz), .busIn_byte_enables(be), .busIn_data_valid(dv && sel == 1),
        .busIn_end_transaction(endt && sel == 1),
        .busOut_address_data(o_ad1), .busOut_data_valid(o_dv1), .busOut_end_transaction(o_end1),
        .busOut_busy(o_busy1), .busOut_error(o_err1)
    );

    always_comb begin
        if (sel == 1) begin
            r_ad = o_ad1; r_dv = o_dv1; r_end = o_end1; r_busy = o_busy1; r_err = o_err1;
        end else begin
            r_ad = o_ad0; r_dv = o_dv0; r_end = o_end0; r_busy = o_busy0; r_err = o_err0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? BASE1 : BASE0;
    endfunction

    function automatic bit model_err(input int d, input logic [31:0] a, input logic [7:0] b);
        logic [31:0] base;
        base = base_of(d);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < base) return 1'b1;
        return (((a - base) >> 2) + 32'(b)) >= 32'(DEPTH);
    endfunction

    function automatic bit exp_busy(input bit e, input int per, input bit prev, input int wr);
        if (e || per == 0 || !prev) return 1'b0;
        return (wr % per) == 0;
    endfunction

    task automatic sample_flags();
        flag_err += int'(r_err);
        flag_end += int'(r_end);
        flag_dv  += int'(r_dv);
        if (r_err !== r_end) flag_mis++;
    endtask

    task automatic clear_flags();
        flag_err = 0; flag_end = 0; flag_dv = 0; flag_mis = 0;
    endtask

    // Caller is at a falling edge; master waits one cycle after begin before data.
    task automatic do_write(input int d, input logic [31:0] a, input logic [7:0] b, input int n,
                            input logic [3:0] bm, input logic [31:0] d0, input logic [31:0] step,
                            input bit exp_err);
        int i, wr, guard, idx, per;
        bit prev, bsy;
        logic [31:0] w;
        per = (d == 1) ? PER1 : PER0;
        idx = int'((a - base_of(d)) >> 2);
        i = 0; wr = 0; guard = 0; prev = 1'b0;
        clear_flags();
        sel = d; begin_t = 1'b1; ad = a; rnw = 1'b0; bsz = b; be = bm;
        @(negedge clock);
        begin_t = 1'b0; ad = 32'h0;
        sample_flags();
        @(negedge clock);
        while (i < n && guard < 4 * n + 8) begin
            sample_flags();
            check("wr_busy", 32'(r_busy), 32'(exp_busy(exp_err, per, prev, wr)));
            w = d0 + step * 32'(i);
            dv = 1'b1; ad = w;
            bsy = r_busy;
            @(negedge clock);
            guard++;
            prev = 1'b0;
            if (!bsy) begin
                if (!exp_err && wr < int'(b) + 1) begin
                    for (int bi = 0; bi < 4; bi++)
                        if (bm[bi]) mm[d][idx + wr][8*bi +: 8] = w[8*bi +: 8];
                    wr++;
                    prev = 1'b1;
                end
                i++;
            end
        end
        if (i < n) check("wr_timeout", 32'(i), 32'(n));
        sample_flags();
        check("wr_busy_last", 32'(r_busy), 32'(exp_busy(exp_err, per, prev, wr)));
        dv = 1'b0; ad = 32'h0; endt = 1'b1;
        @(negedge clock);
        sample_flags();
        endt = 1'b0;
        repeat (3) begin
            @(negedge clock);
            sample_flags();
        end
        check("wr_err_pulses", 32'(flag_err), 32'(exp_err));
        check("wr_end_pulses", 32'(flag_end), 32'(exp_err));
        check("wr_err_end_align", 32'(flag_mis), 32'd0);
        check("wr_no_valid", 32'(flag_dv), 32'd0);
    endtask

    // Returns at the falling edge one cycle after the end pulse.
    task automatic do_read(input int d, input logic [31:0] a, input logic [7:0] b, input bit exp_err,
                           input bit inject, output logic [31:0] last_word);
        beat_t q[$];
        beat_t zb;
        int lat, per, idx, n;
        zb = '{1'b0, 32'h0, 1'b0};
        lat = (d == 1) ? LAT1 : LAT0;
        per = (d == 1) ? PER1 : PER0;
        n = int'(b) + 1;
        last_word = 32'h0;
        sel = d; begin_t = 1'b1; ad = a; rnw = 1'b1; bsz = b;
        @(negedge clock);
        begin_t = 1'b0; ad = 32'h0;
        if (exp_err) begin
            clear_flags();
            for (int j = 0; j < 6; j++) begin
                sample_flags();
                if (j < 5) @(negedge clock);
            end
            check("rd_err_pulses", 32'(flag_err), 32'd1);
            check("rd_err_end", 32'(flag_end), 32'd1);
            check("rd_err_end_align", 32'(flag_mis), 32'd0);
            check("rd_err_no_valid", 32'(flag_dv), 32'd0);
            return;
        end
        idx = int'((a - base_of(d)) >> 2);
        for (int j = 0; j < lat + 2; j++) q.push_back(zb);
        for (int k = 0; k < n; k++) begin
            q.push_back('{1'b1, mm[d][idx + k], 1'b0});
            if (per > 0 && (k + 1) % per == 0 && k != n - 1) q.push_back(zb);
        end
        q.push_back('{1'b0, 32'h0, 1'b1});
        q.push_back(zb);
        for (int j = 0; j < q.size(); j++) begin
            if (inject && j == lat + 3) begin
                begin_t = 1'b1; ad = base_of(d); rnw = 1'b0; bsz = 8'd0;
            end else begin
                begin_t = 1'b0; rnw = 1'b1;
            end
            check("rd_valid", 32'(r_dv), 32'(q[j].v));
            check("rd_data", r_ad, q[j].data);
            check("rd_end", 32'(r_end), 32'(q[j].e));
            check("rd_err", 32'(r_err), 32'd0);
            if (q[j].v) last_word = r_ad;
            if (j < q.size() - 1) @(negedge clock);
        end
        begin_t = 1'b0; rnw = 1'b1; ad = 32'h0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tv[$];
        logic [31:0] lw;
        int          cnt, d, idx;
        logic [31:0] a;
        logic [7:0]  b;
        bit          e;

        reset = 1'b1; begin_t = 1'b0; ad = 32'h0; rnw = 1'b0; bsz = 8'd0;
        be = 4'h0; dv = 1'b0; endt = 1'b0; sel = 0;
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            sel = k;
            #1;
            check("reset_data", r_ad, 32'h0);
            check("reset_valid", 32'(r_dv), 32'd0);
            check("reset_end", 32'(r_end), 32'd0);
            check("reset_busy", 32'(r_busy), 32'd0);
            check("reset_err", 32'(r_err), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Fill both memories so every read has a known expectation.
        for (int k = 0; k < 2; k++)
            for (int blk = 0; blk < 4; blk++)
                do_write(k, base_of(k) + 32'(blk * 1024), 8'd255, 256, 4'hF, $urandom, $urandom, 1'b0);

        tv.push_back('{0, 1'b0, 32'h0000_0010, 8'd3, 4, 4'hF, 32'h11, 32'h11, 1'b0, 1'b0});
        tv.push_back('{0, 1'b1, 32'h0000_0010, 8'd3, 4, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1});
        tv.push_back('{1, 1'b0, 32'h0000_1010, 8'd5, 6, 4'hF, 32'hC0DE_0001, 32'h101, 1'b0, 1'b0});
        tv.push_back('{1, 1'b1, 32'h0000_1010, 8'd4, 5, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});
        tv.push_back('{0, 1'b1, 32'h0000_0022, 8'd0, 1, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0});
        tv.push_back('{1, 1'b1, 32'h0000_0FFC, 8'd0, 1, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0});
        tv.push_back('{0, 1'b0, 32'h0000_0FF0, 8'd7, 8, 4'hF, 32'hDEAD_0000, 32'h1, 1'b1, 1'b0});
        tv.push_back('{0, 1'b0, 32'h0000_0FF0, 8'd4, 5, 4'hF, 32'hBEEF_0000, 32'h1, 1'b1, 1'b0});
        tv.push_back('{0, 1'b1, 32'h0000_0FF0, 8'd3, 4, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});
        tv.push_back('{1, 1'b0, 32'h0000_1022, 8'd1, 2, 4'hF, 32'h5555_0000, 32'h1, 1'b1, 1'b0});
        tv.push_back('{0, 1'b0, 32'h0000_0040, 8'd1, 3, 4'hF, 32'hAAAA_0000, 32'h1, 1'b0, 1'b0});
        tv.push_back('{0, 1'b1, 32'h0000_0040, 8'd2, 3, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});
        tv.push_back('{1, 1'b1, 32'h0000_1FFC, 8'd0, 1, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});
        tv.push_back('{1, 1'b1, 32'h0000_1FF8, 8'd1, 2, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});

        foreach (tv[i]) begin
            if (tv[i].rd)
                do_read(tv[i].d, tv[i].addr, tv[i].burst, tv[i].err, tv[i].inject, lw);
            else
                do_write(tv[i].d, tv[i].addr, tv[i].burst, tv[i].n, tv[i].bm, tv[i].d0, tv[i].step, tv[i].err);
        end

        // Ordered burst readback, then a begin one cycle after the end pulse.
        do_read(0, 32'h0000_0010, 8'd3, 1'b0, 1'b0, lw);
        check("burst_last_word", lw, 32'h44);
        do_read(0, 32'h0000_0010, 8'd0, 1'b0, 1'b0, lw);
        check("back_to_back_first", lw, 32'h11);

        // Byte-lane merge.
        do_write(0, 32'h0000_0020, 8'd0, 1, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0);
        do_write(0, 32'h0000_0020, 8'd0, 1, 4'b0001, 32'h0000_0099, 32'h0, 1'b0);
        do_read(0, 32'h0000_0020, 8'd0, 1'b0, 1'b0, lw);
        check("byte_merge", lw, 32'hAABB_CC99);

        // Reset during the third word of an 8-word read.
        sel = 0; begin_t = 1'b1; ad = 32'h0000_0100; rnw = 1'b1; bsz = 8'd7;
        @(negedge clock);
        begin_t = 1'b0;
        cnt = 0;
        for (int j = 0; j < 20 && cnt < 3; j++) begin
            @(negedge clock);
            if (r_dv) cnt++;
        end
        check("rst_reach_word3", 32'(cnt), 32'd3);
        check("rst_word3_data", r_ad, mm[0][66]);
        reset = 1'b1;
        #1;
        check("rst_async_data", r_ad, 32'h0);
        check("rst_async_valid", 32'(r_dv), 32'd0);
        check("rst_async_end", 32'(r_end), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_read(0, 32'h0000_0100, 8'd7, 1'b0, 1'b0, lw);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            d   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, DEPTH - 1));
            b   = 8'($urandom_range(0, 15));
            a   = base_of(d) + 32'(idx * 4);
            case ($urandom_range(0, 7))
                0: a = a + 32'($urandom_range(1, 3));
                1: if (d == 1) a = base_of(d) - 32'($urandom_range(1, 16) * 4);
                default: ;
            endcase
            e = model_err(d, a, b);
            if ($urandom_range(0, 1) == 1)
                do_read(d, a, b, e, 1'b0, lw);
            else
                do_write(d, a, b, int'(b) + 1, 4'($urandom_range(1, 15)), $urandom, $urandom, e);
        end
        for (int k = 0; k < 2; k++)
            for (int blk = 0; blk < 4; blk++)
                do_read(k, base_of(k) + 32'(blk * 1024), 8'd255, 1'b0, 1'b0, lw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
